// File: rtl/fft_bitrev_reorder_if.sv
// Sample bus for the FFT bit-reverse reorder buffer.
// The DUT uses the slave modport and the producer/consumer uses the master modport.
// The sof_i signal exists only when FFT_REORDER_SOF_EN is defined.
interface fft_bitrev_reorder_if #(
  parameter int DATA_W = 16,
  parameter int N_LOG2 = 5
);
  logic              valid_i;
  logic [DATA_W-1:0] data_in_r;
  logic [DATA_W-1:0] data_in_i;
`ifdef FFT_REORDER_SOF_EN
  logic              sof_i;
`endif
  logic              valid_o;
  logic [DATA_W-1:0] data_out_r;
  logic [DATA_W-1:0] data_out_i;
  logic              sof_o;
  logic [N_LOG2-1:0] bin_o;

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, data_out_r, data_out_i, sof_o, bin_o
`ifdef FFT_REORDER_SOF_EN
    , input sof_i
`endif
  );

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, data_out_r, data_out_i, sof_o, bin_o
`ifdef FFT_REORDER_SOF_EN
    , output sof_i
`endif
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Output-side reorder buffer for the 32-point SDF FFT.
// Samples arrive in bit-reversed order and are written into one bank of a ping-pong buffer.
// Each completed bank is read out in natural bin order as one contiguous burst.
// Optional macro FFT_REORDER_SOF_EN adds sof_i, which resynchronises the write counter to
// the upstream frame boundary.
module fft_bitrev_reorder #(
  parameter int DATA_W = 16,
  parameter int N_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_bitrev_reorder_if.slave  bus
);
  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
    for (int b = 0; b < N_LOG2; b++) bitrev[b] = x[N_LOG2-1-b];
  endfunction

  // Input register stage; all write logic works from these copies.
  logic              vld_q;
  logic [DATA_W-1:0] dr_q, di_q;
`ifdef FFT_REORDER_SOF_EN
  logic              sof_q;
`endif

  // Capture the incoming sample and its qualifiers.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      dr_q  <= '0;
      di_q  <= '0;
`ifdef FFT_REORDER_SOF_EN
      sof_q <= 1'b0;
`endif
    end else begin
      vld_q <= bus.valid_i;
      dr_q  <= bus.data_in_r;
      di_q  <= bus.data_in_i;
`ifdef FFT_REORDER_SOF_EN
      sof_q <= bus.sof_i;
`endif
    end
  end

  // Write side: effective index, frame completion, and next counter/bank.
  logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d, wr_idx;
  logic              wr_bank_q, wr_bank_d;
  logic              frame_done;

  // Compute the write-side next state.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    wr_idx = wr_cnt_q;
`ifdef FFT_REORDER_SOF_EN
    if (vld_q && sof_q) wr_idx = '0;
`endif
    frame_done = vld_q && (wr_idx == LAST);
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    if (vld_q) begin
      wr_cnt_d = wr_idx + 1'b1;
      if (frame_done) wr_bank_d = ~wr_bank_q;
    end
  end

  // Update the write counter and the write bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  // Ping-pong storage, with the bank select as the address MSB.
  logic [2*DATA_W-1:0] mem_q [2*N];

  // Scatter each sample to its bit-reversed slot in the write bank.
  // NOTE: the memory has no reset; every slot is written before its bank is read.
  always_ff @(posedge clk) begin
    if (vld_q) mem_q[{wr_bank_q, bitrev(wr_idx)}] <= {dr_q, di_q};
  end

  // Read FSM.
  logic [0:0]        state_q, state_d;
  logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;

  // Launch on bank completion, step rd_cnt once per cycle, and chain into the next frame
  // when it completes on the last read cycle.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    if (state_q == S_IDLE) begin
      if (frame_done) begin
        state_d  = S_READ;
        rd_cnt_d = '0;
      end
    end else begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST) state_d = frame_done ? S_READ : S_IDLE;
    end
  end

  // Update the FSM state and the read counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Registered output; the read bank is always the one not being written.
  logic              valid_q, sof_oq;
  logic [N_LOG2-1:0] bin_q;
  logic [DATA_W-1:0] out_r_q, out_i_q;

  // Register the read data and its sideband signals.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      sof_oq  <= 1'b0;
      bin_q   <= '0;
      out_r_q <= '0;
      out_i_q <= '0;
    end else if (state_q == S_READ) begin
      valid_q            <= 1'b1;
      sof_oq             <= (rd_cnt_q == '0);
      bin_q              <= rd_cnt_q;
      {out_r_q, out_i_q} <= mem_q[{~wr_bank_q, rd_cnt_q}];
    end else begin
      valid_q <= 1'b0;
      sof_oq  <= 1'b0;
    end
  end

  assign bus.valid_o    = valid_q;
  assign bus.sof_o      = sof_oq;
  assign bus.bin_o      = bin_q;
  assign bus.data_out_r = out_r_q;
  assign bus.data_out_i = out_i_q;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder.
// A frame-level model stores each input sample at its natural bin and schedules the expected
// burst on the cycle the frame completes. A monitor on the falling edge compares every output
// cycle against that schedule.
module tb_fft_bitrev_reorder;
  localparam int DATA_W = 16;
  localparam int N_LOG2 = 5;
  localparam int N      = 1 << N_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) bus ();
  fft_bitrev_reorder #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model.
  typedef struct {
    int unsigned cyc;
    logic [15:0] r;
    logic [15:0] i;
    int          bin;
  } exp_t;

  exp_t        q[$];
  logic [15:0] frm_r [N];
  logic [15:0] frm_i [N];
  int          m_cnt = 0;

  function automatic int brev(input int j);
    int r = 0;
    for (int b = 0; b < N_LOG2; b++)
      if (((j >> b) & 1) != 0) r += 1 << (N_LOG2 - 1 - b);
    return r;
  endfunction

  // The sample with arrival index m_cnt belongs at natural bin brev(m_cnt). A full frame
  // appears from cycle (drive cycle of the last sample) + 3, one bin per cycle.
  task automatic model_push(input logic [15:0] r, input logic [15:0] i);
    frm_r[brev(m_cnt)] = r;
    frm_i[brev(m_cnt)] = i;
    m_cnt++;
    if (m_cnt == N) begin
      m_cnt = 0;
      for (int k = 0; k < N; k++) q.push_back('{cyc + 3 + k, frm_r[k], frm_i[k], k});
    end
  endtask

  task automatic send(input bit v, input logic [15:0] r, input logic [15:0] i);
    @(posedge clk); #1;
    bus.valid_i   = v;
    bus.data_in_r = r;
    bus.data_in_i = i;
`ifdef FFT_REORDER_SOF_EN
    bus.sof_i     = 1'b0;
`endif
    if (v) model_push(r, i);
  endtask

`ifdef FFT_REORDER_SOF_EN
  task automatic send_sof(input bit v, input logic [15:0] r, input logic [15:0] i);
    @(posedge clk); #1;
    bus.valid_i   = v;
    bus.data_in_r = r;
    bus.data_in_i = i;
    bus.sof_i     = 1'b1;
    if (v) begin
      m_cnt = 0;
      model_push(r, i);
    end
  endtask
`endif

  task automatic send_rand(input bit v);
    send(v, 16'($urandom), 16'($urandom));
  endtask

  task automatic drain();
    send(1'b0, 16'h0, 16'h0);
    for (int n = 0; n < 200 && q.size() > 0; n++) @(posedge clk);
    repeat (4) @(posedge clk);
    check("drain_left", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    q.delete();
    m_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Output monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      check("rst_valid", 32'(bus.valid_o), 32'd0);
      check("rst_sof",   32'(bus.sof_o),   32'd0);
      check("rst_bin",   32'(bus.bin_o),   32'd0);
      check("rst_data",  {bus.data_out_r, bus.data_out_i}, 32'd0);
    end else if (bus.valid_o) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("out_cycle", cyc, e.cyc);
        check("data_r",    32'(bus.data_out_r), 32'(e.r));
        check("data_i",    32'(bus.data_out_i), 32'(e.i));
        check("bin",       32'(bus.bin_o),      32'(e.bin));
        check("sof",       32'(bus.sof_o),      32'(e.bin == 0));
      end
    end else begin
      check("idle_sof", 32'(bus.sof_o), 32'd0);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        check("missing_valid", 32'd0, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
`ifdef FFT_REORDER_SOF_EN
    bus.sof_i     = 1'b0;
`endif
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Ramp frame at full rate.
    for (int j = 0; j < N; j++) send(1'b1, 16'(brev(j)), 16'(-brev(j)));
    drain();

    // Two back-to-back frames; the second is offset by 100.
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < N; j++) send(1'b1, 16'(brev(j) + f * 100), 16'(-(brev(j) + f * 100)));
    drain();

    // Gapped input: valid on every third cycle.
    for (int j = 0; j < N; j++) begin
      send_rand(1'b1);
      send_rand(1'b0);
      send_rand(1'b0);
    end
    drain();

    // Extreme values at input slots 1 and 30.
    for (int j = 0; j < N; j++) begin
      if (j == 1)       send(1'b1, 16'h8000, 16'h8000);
      else if (j == 30) send(1'b1, 16'h7fff, 16'h7fff);
      else              send_rand(1'b1);
    end
    drain();

    // Partial frame waits indefinitely, then reset discards it.
    for (int j = 0; j < 20; j++) send_rand(1'b1);
    for (int j = 0; j < 60; j++) send_rand(1'b0);
    do_reset();
    for (int j = 0; j < N; j++) send_rand(1'b1);
    drain();

    // Reset in the middle of a read burst.
    for (int j = 0; j < N; j++) send_rand(1'b1);
    repeat (12) send_rand(1'b0);
    do_reset();
    repeat (40) send_rand(1'b0);
    check("after_reset_queue", 32'(q.size()), 32'd0);

    // Random valid pattern over three frames.
    for (int n = 0; n < 3 * N; ) begin
      if ($urandom_range(0, 9) < 7) begin
        send_rand(1'b1);
        n++;
      end else begin
        send_rand(1'b0);
      end
    end
    drain();

`ifdef FFT_REORDER_SOF_EN
    // A partial frame is abandoned by sof_i; a sof_i with valid low is ignored.
    for (int j = 0; j < 10; j++) send_rand(1'b1);
    send_sof(1'b0, 16'h1234, 16'h1234);
    for (int j = 0; j < N; j++) begin
      if (j == 0) send_sof(1'b1, 16'(brev(j)), 16'(-brev(j)));
      else        send(1'b1, 16'(brev(j)), 16'(-brev(j)));
    end
    drain();
`endif

    check("final_queue", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side consumer of the 32-point SDF FFT pipeline.
- Accepts final-stage butterfly samples, which arrive in bit-reversed index order, and re-emits each frame in natural order (bin 0..N-1).
- Ping-pong double buffer: one bank is written while the other is read out as a contiguous 32-cycle burst.

Parameters:
- DATA_W, 16, width of each real/imag sample (two's complement).
- N_LOG2, 5, log2 of frame length (N = 32).

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  asynchronous active-low reset.
- valid_i  input  1  qualifies data_in_r/data_in_i this cycle.
- data_in_r  input  DATA_W  real part, bit-reversed order.
- data_in_i  input  DATA_W  imag part, bit-reversed order.
- valid_o  output  1  qualifies output sample.
- data_out_r  output  DATA_W  real part, natural order.
- data_out_i  output  DATA_W  imag part, natural order.
- sof_o  output  1  high with bin 0 of each output frame.
- bin_o  output  N_LOG2  natural bin index of current output sample.

Behaviour:
- Inputs (valid_i, data) are registered once before any use. Write logic acts on the registered copy.
- Storage: two banks, each N x (2*DATA_W). wr_bank selects the write bank; the read side reads the opposite bank.
- Write side:
  - wr_cnt counts 0..N-1, incrementing only on a registered valid.
  - The sample with wr_cnt = j is written to address bitrev(j), where bitrev reverses the N_LOG2 bits (j=1 -> 16, j=3 -> 24).
  - On the write with wr_cnt = N-1: wr_cnt wraps to 0, wr_bank toggles, and a read of the just-filled bank is launched.
- Read FSM states:
  - IDLE: valid_o = 0. Go to READ when a bank completes.
  - READ: rd_cnt steps 0..N-1, one per cycle, with no gaps. Output is registered: data_out = bank[rd_cnt], bin_o = rd_cnt, valid_o = 1, sof_o = (rd_cnt == 0).
  - After rd_cnt = N-1: go to IDLE, or restart at rd_cnt = 0 if another bank completed on that same cycle. Back-to-back frames therefore stream with no bubble.
- Latency: if the N-th valid_i of a frame is sampled at cycle T, bin k of that frame appears at cycle T+3+k (input reg + write + registered read).
- Throughput: at most one input per cycle, so the next bank cannot complete before the current read finishes. No overflow case exists and no back-pressure is provided.
- Gapped input (valid_i low for any cycles):
  - The write side holds its state.
  - The output burst is still 32 contiguous cycles once the frame completes.
- Data is passed bit-exact; no scaling, rounding or sign change.
- Reset values, in any state:
  - valid_o = 0, sof_o = 0, data_out_r/i = 0, bin_o = 0.
  - wr_cnt = 0, rd_cnt = 0, wr_bank = 0, FSM = IDLE.
- Reset mid-frame or mid-read discards the partial frame and the remaining burst. Memory contents need no reset and are never output before being written.
- Partial frame with valid_i held low indefinitely: no output is produced and the frame waits.

Optional Feature:
- Macro: FFT_REORDER_SOF_EN.
- Defined:
  - Adds input port sof_i (1 bit), sampled through the input register together with valid_i.
  - A registered valid with sof_i = 1 forces that sample to be treated as wr_cnt = 0. The partial frame in the write bank is abandoned, with no bank toggle and no read launched.
  - A registered sof_i with valid low is ignored.
  - This resynchronises to the upstream CTRL frame boundary.
- Undefined: no sof_i port; wr_cnt free-runs modulo N on valid only.

Test Plan:
- Ramp frame: feed data_in_r = bitrev(j), data_in_i = -bitrev(j) for j = 0..31 at full rate -> 32 contiguous valid_o cycles with data_out_r = 0..31, data_out_i = 0..-31, sof_o only with bin 0, first output at T+3.
- Back-to-back frames: two full-rate frames, the second with values +100 -> 64 consecutive valid_o cycles, no gap, second burst = 100..131 in natural order.
- Gapped input: valid_i every 3rd cycle for one frame -> no output until the 32nd sample, then a contiguous 32-cycle burst starting at T+3.
- Extremes: samples -32768 and 32767 at bit-reversed slots 1 and 30 -> appear bit-exact at bins 16 and 15.
- Reset: assert rst after 20 samples, release, then feed a full frame -> valid_o stays 0 until T+3 of the new frame, and no stale data is emitted.
- With FFT_REORDER_SOF_EN: 10 samples, then sof_i = 1 with a fresh ramp frame -> the output equals the fresh frame only, with exactly one 32-cycle burst.
